// File: rtl/cpu_pkg.sv
// Shared constants for the CPU program-loading path: data widths and the
// loader state encoding.
package cpu_pkg;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: collects accepted bytes and flags the
// byte that completes a word (4th byte or the image's last byte).
module byte_packer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              take,
  input  logic [BYTE_W-1:0] data,
  input  logic              last,
  output logic              vld_p0,
  output logic [WORD_W-1:0] word_p0
);

  logic [1:0]        byte_cnt;
  logic [WORD_W-1:0] asm_q;

  // The bytes above the current one are still zero, so a short final word
  // comes out zero-padded without any extra masking.
  always_comb begin
    word_p0 = asm_q;
    word_p0[{byte_cnt, 3'b000} +: BYTE_W] = data;
    vld_p0 = take && ((byte_cnt == 2'd3) || last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= 2'd0;
      asm_q    <= '0;
    end else if (take) begin
      if (vld_p0) begin
        byte_cnt <= 2'd0;
        asm_q    <= '0;
      end else begin
        byte_cnt <= byte_cnt + 2'd1;
        asm_q    <= word_p0;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory image writer: turns a byte stream into word writes and
// releases the CPU once the final byte has been stored.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int MAX_WORDS = 256,
  parameter int IDX_W     = $clog2(MAX_WORDS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [WORD_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_start,
  output logic              done,
  output logic              err,
  output logic [IDX_W-1:0]  words_loaded
);

  logic [1:0]        state;
  logic [IDX_W-1:0]  word_idx;
  logic              take;
  logic              ovf;
  logic              vld_p0;
  logic [WORD_W-1:0] word_p0;

  function automatic logic [WORD_W-1:0] byte_addr(input logic [IDX_W-1:0] idx);
    byte_addr = '0;
    byte_addr[IDX_W+1:0] = {idx, 2'b00};
  endfunction

  assign in_ready     = (state == ST_LOAD);
  assign take         = in_valid && in_ready;
  assign ovf          = take && (word_idx == IDX_W'(MAX_WORDS));
  assign err          = (state == ST_ERR);
  assign words_loaded = word_idx;

  byte_packer u_pack (
    .clk     (clk),
    .rst     (rst),
    .take    (take && !ovf),
    .data    (in_data),
    .last    (in_last),
    .vld_p0  (vld_p0),
    .word_p0 (word_p0)
  );

  // Stage p0 -> p1: completed word becomes the registered write, and the
  // RUN/ERR decision lands on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      word_idx  <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      cpu_start <= 1'b0;
    end else begin
      wr_en <= vld_p0;
      if (vld_p0) begin
        wr_addr  <= byte_addr(word_idx);
        wr_data  <= word_p0;
        word_idx <= word_idx + 1'b1;
      end
      if (ovf)
        state <= ST_ERR;
      else if (vld_p0 && in_last)
        state <= ST_RUN;
      done      <= (state == ST_RUN);
      cpu_start <= (state == ST_RUN);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random byte streams into a full-size
// and a two-word instance, checked against a packing model.
module tb_imem_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr    = 0;

  logic        a_rst, a_valid, a_last, a_ready, a_wr_en, a_start, a_done, a_err;
  logic [7:0]  a_data;
  logic [31:0] a_wr_addr, a_wr_data;
  logic [8:0]  a_words;

  logic        b_rst, b_valid, b_last, b_ready, b_wr_en, b_start, b_done, b_err;
  logic [7:0]  b_data;
  logic [31:0] b_wr_addr, b_wr_data;
  logic [1:0]  b_words;

  imem_loader #(.MAX_WORDS(256)) dut_a (
    .clk(clk), .rst(a_rst), .in_valid(a_valid), .in_data(a_data), .in_last(a_last),
    .in_ready(a_ready), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .cpu_start(a_start), .done(a_done), .err(a_err), .words_loaded(a_words)
  );

  imem_loader #(.MAX_WORDS(2)) dut_b (
    .clk(clk), .rst(b_rst), .in_valid(b_valid), .in_data(b_data), .in_last(b_last),
    .in_ready(b_ready), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .cpu_start(b_start), .done(b_done), .err(b_err), .words_loaded(b_words)
  );

  logic [31:0] qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];

  always @(negedge clk) begin
    if (a_wr_en === 1'b1) begin
      qa_addr.push_back(a_wr_addr);
      qa_data.push_back(a_wr_data);
    end
    if (b_wr_en === 1'b1) begin
      qb_addr.push_back(b_wr_addr);
      qb_data.push_back(b_wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic l);
    if (sel == 0) begin
      a_valid = v; a_data = d; a_last = l;
    end else begin
      b_valid = v; b_data = d; b_last = l;
    end
  endtask

  task automatic do_reset(input int sel);
    drive(sel, 1'b0, 8'h00, 1'b0);
    if (sel == 0) a_rst = 1'b1; else b_rst = 1'b1;
    @(posedge clk); #1;
    if (sel == 0) a_rst = 1'b0; else b_rst = 1'b0;
  endtask

  task automatic snap(input int sel, output logic rdy, output logic we, output logic st,
                      output logic dn, output logic er, output logic [31:0] wl);
    if (sel == 0) begin
      rdy = a_ready; we = a_wr_en; st = a_start; dn = a_done; er = a_err; wl = 32'(a_words);
    end else begin
      rdy = b_ready; we = b_wr_en; st = b_start; dn = b_done; er = b_err; wl = 32'(b_words);
    end
  endtask

  // Image packing rule: word i holds bytes 4i..4i+3 little-endian, missing
  // bytes are zero; anything past maxw words is an overflow.
  task automatic model(input logic [7:0] b[$], input int maxw,
                       output logic [31:0] w[$], output bit ovf);
    int n  = b.size();
    int nw = (n + 3) / 4;
    w = {};
    ovf = (nw > maxw);
    if (ovf) nw = maxw;
    for (int i = 0; i < nw; i++) begin
      logic [31:0] word = 32'h0;
      for (int k = 0; k < 4; k++)
        if (4 * i + k < n) word = word | (32'(b[4 * i + k]) << (8 * k));
      w.push_back(word);
    end
  endtask

  // gap_mode: 0 continuous, 1 alternate idle cycles, 2 random idle cycles
  task automatic scenario(input string name, input int sel, input logic [7:0] b[$],
                          input bit use_last, input int gap_mode);
    logic [31:0] w[$];
    bit          ovf;
    int          base, maxw, got;
    logic        rdy, we, st, dn, er;
    logic [31:0] wl;
    maxw = (sel == 0) ? 256 : 2;
    base = (sel == 0) ? qa_addr.size() : qb_addr.size();
    model(b, maxw, w, ovf);
    for (int i = 0; i < b.size(); i++) begin
      if ((gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
        drive(sel, 1'b0, 8'($urandom), 1'($urandom));
        @(posedge clk); #1;
      end
      drive(sel, 1'b1, b[i], use_last && (i == b.size() - 1));
      @(posedge clk); #1;
    end
    drive(sel, 1'b0, 8'h00, 1'b0);
    snap(sel, rdy, we, st, dn, er, wl);
    if (!ovf) begin
      chk({name, "_final_wr_en"}, 32'(we), 32'd1);
      chk({name, "_start_early"}, 32'(st), 32'd0);
      chk({name, "_ready_drop"}, 32'(rdy), 32'd0);
      @(posedge clk); #1;
      snap(sel, rdy, we, st, dn, er, wl);
      chk({name, "_cpu_start"}, 32'(st), 32'd1);
      chk({name, "_done"}, 32'(dn), 32'd1);
      chk({name, "_wr_en_off"}, 32'(we), 32'd0);
      chk({name, "_err"}, 32'(er), 32'd0);
      chk({name, "_words_loaded"}, wl, 32'(w.size()));
    end else begin
      chk({name, "_err"}, 32'(er), 32'd1);
      chk({name, "_ready"}, 32'(rdy), 32'd0);
      chk({name, "_wr_en"}, 32'(we), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      snap(sel, rdy, we, st, dn, er, wl);
      chk({name, "_cpu_start"}, 32'(st), 32'd0);
      chk({name, "_done"}, 32'(dn), 32'd0);
      chk({name, "_words_loaded"}, wl, 32'(maxw));
    end
    got = ((sel == 0) ? qa_addr.size() : qb_addr.size()) - base;
    chk({name, "_nwrites"}, 32'(got), 32'(w.size()));
    for (int i = 0; i < w.size() && i < got; i++) begin
      chk($sformatf("%s_addr%0d", name, i),
          (sel == 0) ? qa_addr[base + i] : qb_addr[base + i], 32'(4 * i));
      chk($sformatf("%s_data%0d", name, i),
          (sel == 0) ? qa_data[base + i] : qb_data[base + i], w[i]);
    end
  endtask

  logic [7:0] t1[$] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  logic [7:0] t2[$] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
  logic [7:0] t4[$] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
  logic [7:0] rq[$];

  initial begin
    int n0;
    a_rst = 1'b0; b_rst = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    #1;

    do_reset(0);
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_wr_en", 32'(a_wr_en), 32'd0);
    chk("rst_wr_addr", a_wr_addr, 32'h0);
    chk("rst_wr_data", a_wr_data, 32'h0);
    chk("rst_cpu_start", 32'(a_start), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_words", 32'(a_words), 32'd0);

    scenario("t1_basic", 0, t1, 1'b1, 0);
    do_reset(0);
    scenario("t2_tail", 0, t2, 1'b1, 0);
    do_reset(0);
    scenario("t3_gapped", 0, t1, 1'b1, 1);

    do_reset(1);
    scenario("t4_overflow", 1, t4, 1'b0, 0);
    do_reset(1);
    scenario("t5_exact_fill", 1, t1, 1'b1, 2);

    do_reset(0);
    n0 = qa_addr.size();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, t2[i], 1'b0);
      @(posedge clk); #1;
    end
    do_reset(0);
    @(posedge clk); #1;
    chk("t6_no_prereset_write", 32'(qa_addr.size()), 32'(n0));
    chk("t6_words_after_rst", 32'(a_words), 32'd0);
    scenario("t6_reset_mid", 0, t1, 1'b1, 0);

    for (int r = 0; r < 4; r++) begin
      rq = {};
      for (int i = 0; i < int'($urandom_range(1, 24)); i++) rq.push_back(8'($urandom));
      do_reset(0);
      scenario($sformatf("rnd_a%0d", r), 0, rq, 1'b1, 2);
    end
    for (int r = 0; r < 2; r++) begin
      rq = {};
      for (int i = 0; i < int'($urandom_range(9, 12)); i++) rq.push_back(8'($urandom));
      do_reset(1);
      scenario($sformatf("rnd_b%0d", r), 1, rq, 1'b0, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program-image writer for the instruction memory that the single-cycle CPU reads.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Issues one write per word to the instruction-memory write port.
- Once the image is complete, raises cpu_start, which drives the CPU's start input. The CPU is held in reset until the image is loaded.

Parameters:
- MAX_WORDS, 256, instruction-memory capacity in 32-bit words; writes beyond it are an error.
- IDX_W, $clog2(MAX_WORDS)+1, width of the word index/counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  byte on in_data is valid
- in_data  in  8  image byte, little-endian order
- in_last  in  1  qualifies the final byte of the image
- in_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  instruction-memory write strobe, one cycle per word
- wr_addr  out  32  byte address of the written word (word_idx*4)
- wr_data  out  32  assembled word
- cpu_start  out  1  high = CPU released from reset
- done  out  1  image fully written
- err  out  1  sticky overflow flag
- words_loaded  out  IDX_W  words written so far

Behaviour:
- Clock and reset:
  - One clock domain. Reset is synchronous and active-high on clk/rst.
  - All registers update on the rising clk edge.
- Reset values:
  - State LOAD, byte_cnt=0, word_idx=0, asm register=0.
  - wr_en=0, wr_addr=0, wr_data=0.
  - cpu_start=0, done=0, err=0, words_loaded=0, in_ready=1 (combinational from state).
- States:
  - LOAD: in_ready=1.
  - RUN: in_ready=0, done=1, cpu_start=1.
  - ERR: in_ready=0, err=1, cpu_start=0.
  - No exit from RUN or ERR except rst.
- Handshake:
  - A byte is accepted when in_valid && in_ready.
  - in_valid may drop between bytes; in_data and in_last are ignored without a handshake.
- Assembly:
  - An accepted byte is placed at asm[8*byte_cnt +: 8], and byte_cnt increments mod 4.
  - A word completes on the 4th byte, or on any byte with in_last=1.
  - Unfilled upper bytes of a partial final word are zero.
- Write timing:
  - wr_en is registered, high exactly one cycle, in the cycle after the completing handshake.
  - In that cycle wr_addr = word_idx*4 and wr_data = the completed word.
  - word_idx and words_loaded increment in the same cycle wr_en is high.
  - Back-to-back completions are impossible (minimum 1 byte/cycle gives ≥4 cycles per word, except with in_last), so there are no write collisions.
- Termination:
  - A completing handshake with in_last=1 moves the state to RUN in the same edge that registers the final wr_en.
  - done and cpu_start are therefore first high in the cycle after the final wr_en, and are then held.
  - in_ready drops in the cycle after the in_last handshake.
- Overflow:
  - A byte accepted while word_idx == MAX_WORDS moves the state to ERR. No write is issued and that byte is discarded.
  - Filling exactly MAX_WORDS words with in_last on the final byte is legal and goes to RUN.
- Reset mid-load: returns to the reset values on the next edge. The partial word is discarded and no write is emitted. Memory contents are not cleared.
- Address width: wr_addr is zero-extended from {word_idx, 2'b00}.

Decomposition:
- Shared package (cpu_pkg):
  - localparam WORD_W=32, BYTE_W=8.
  - State enum {LOAD, RUN, ERR} as 2-bit localparams.
- Sub-module: byte_packer, holding byte_cnt, the asm register and the word-complete pulse.
- The top level holds the FSM, word_idx and the write-port registers.

Test Plan:
1. Stream 13 00 00 00 93 00 10 00 (last on the 8th byte), continuous valid -> wr_en at addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093. cpu_start=1 one cycle after the 2nd wr_en; words_loaded=2.
2. Partial tail: 6 bytes AA BB CC DD 11 22 with last on 22 -> writes 0xDDCCBBAA @0x0 and 0x00002211 @0x4, then RUN.
3. Gapped valid: the same 8 bytes as test 1 with in_valid low on alternate cycles, plus garbage on in_data/in_last while invalid -> identical writes. in_last asserted with in_valid low has no effect.
4. MAX_WORDS=2, 9 bytes with no last -> two writes. The 9th byte causes ERR: err=1, in_ready=0, no third wr_en, cpu_start stays 0.
5. MAX_WORDS=2, 8 bytes with last on the 8th -> RUN, err=0.
6. rst pulsed after 3 bytes, then the test 1 stream is sent -> no write from the pre-reset bytes. First write is at addr 0x0 with data 0x00000013.
